// File: rtl/control_pkg.sv
// Shared control/ALU definitions for the multi-cycle RV32I controller.
// Opcodes, funct3 codes, FSM states and store byte-enable patterns.
package control_pkg;

  localparam int ALU_CID_W = 10;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  function automatic logic legal_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_S) || (op == OP_B) || (op == OP_JAL) ||
           (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

endpackage

// File: rtl/control_mc_imm_gen.sv
// Immediate decoder: I/S/B/J/U formats, all sign-extended to 32 bits.
// Purely combinational, driven from the instruction register.
module imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_j,
  output logic [31:0] imm_u
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

endmodule

// File: rtl/control_mc.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Optional CONTROL_MISALIGN_TRAP_EN traps misaligned accesses/targets.
module control_mc
  import control_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ALU_CID_W = 10
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  output logic                 imem_req_out,
  output logic [31:0]          imem_addr_out,
  input  logic                 imem_ack_in,
  input  logic [31:0]          imem_data_in,
  output logic                 dmem_req_out,
  output logic                 dmem_we_out,
  output logic [31:0]          dmem_addr_out,
  output logic [3:0]           dmem_be_out,
  output logic [31:0]          dmem_wdata_out,
  input  logic                 dmem_ack_in,
  input  logic [31:0]          dmem_rdata_in,
  output logic [4:0]           reg_rd_idx1_out,
  output logic [4:0]           reg_rd_idx2_out,
  input  logic [31:0]          reg_rd_data1_in,
  input  logic [31:0]          reg_rd_data2_in,
  output logic                 reg_wr_en_out,
  output logic [4:0]           reg_wr_idx_out,
  output logic [31:0]          reg_wr_data_out,
  output logic [ALU_CID_W-1:0] alu_cid_out,
  output logic [31:0]          alu_arg1_out,
  output logic [31:0]          alu_arg2_out,
  input  logic [31:0]          alu_res_in,
  output logic [31:0]          pc_out,
  output logic                 retire_out,
  output logic                 trap_out
);

  state_t state, state_nx;

  logic [31:0] pc, ir, a, b, imm, res, npc, ea, wdata;
  logic [3:0]  be;

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic       is_r, is_i, is_ld, is_st, is_br;
  logic       is_jal, is_jalr, is_lui, is_auipc;
  logic       is_shift, writes;

  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sel;
  logic [31:0] sum, br_tgt, tgt, ea_mask, ea_al, exec_res, ld;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [15:0] half;
  logic [7:0]  byte_v;
  logic        take, jump, misalign;

  assign op = ir[6:0];
  assign rd = ir[11:7];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];

  assign is_r     = op == OP_R;
  assign is_i     = op == OP_I;
  assign is_ld    = op == OP_LOAD;
  assign is_st    = op == OP_S;
  assign is_br    = op == OP_B;
  assign is_jal   = op == OP_JAL;
  assign is_jalr  = op == OP_JALR;
  assign is_lui   = op == OP_LUI;
  assign is_auipc = op == OP_AUIPC;
  assign is_shift = is_i && (f3 == F3_SLL || f3 == F3_SR);
  assign writes   = is_r || is_i || is_ld || is_jal ||
                    is_jalr || is_lui || is_auipc;

  imm_gen u_imm (
    .instr (ir),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_j (imm_j),
    .imm_u (imm_u)
  );

  // pick the immediate format for the current opcode
  always_comb begin
    imm_sel = imm_i;
    unique case (1'b1)
      is_st:            imm_sel = imm_s;
      is_br:            imm_sel = imm_b;
      is_jal:           imm_sel = imm_j;
      is_lui, is_auipc: imm_sel = imm_u;
      default:          imm_sel = imm_i;
    endcase
  end

  // branch condition from latched rs1/rs2
  always_comb begin
    take = 1'b0;
    case (f3)
      F3_BEQ:  take = a == b;
      F3_BNE:  take = a != b;
      F3_BLT:  take = $signed(a) < $signed(b);
      F3_BGE:  take = $signed(a) >= $signed(b);
      F3_BLTU: take = a < b;
      F3_BGEU: take = a >= b;
      default: take = 1'b0;
    endcase
  end

  assign sum    = a + imm;
  assign br_tgt = pc + imm;
  assign tgt    = is_jalr ? {sum[31:1], 1'b0} : br_tgt;
  assign jump   = is_jal || is_jalr || (is_br && take);

  // access size comes from funct3[1:0]: byte, half, else word
  always_comb begin
    ea_mask = 32'hFFFF_FFFC;
    st_be   = BE_W;
    st_data = b;
    case (f3[1:0])
      SZ_B: begin
        ea_mask = 32'hFFFF_FFFF;
        st_be   = BE_B << ea_al[1:0];
        st_data = {4{b[7:0]}};
      end
      SZ_H: begin
        ea_mask = 32'hFFFF_FFFE;
        st_be   = BE_H << {ea_al[1], 1'b0};
        st_data = {2{b[15:0]}};
      end
      default: begin
        ea_mask = 32'hFFFF_FFFC;
        st_be   = BE_W;
        st_data = b;
      end
    endcase
  end

  assign ea_al = sum & ea_mask;

`ifdef CONTROL_MISALIGN_TRAP_EN
  logic mis_mem;
  assign mis_mem  = (is_ld || is_st) && ((sum & ~ea_mask) != 32'h0);
  assign misalign = mis_mem || (jump && tgt[1]);
`else
  assign misalign = 1'b0;
`endif

  // result produced in EXEC for non-load writebacks
  always_comb begin
    exec_res = alu_res_in;
    unique case (1'b1)
      is_jal, is_jalr: exec_res = pc + 32'd4;
      is_lui:          exec_res = imm;
      is_auipc:        exec_res = br_tgt;
      default:         exec_res = alu_res_in;
    endcase
  end

  assign byte_v = dmem_rdata_in[{ea[1:0], 3'b000} +: 8];
  assign half   = ea[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];

  // load lane select and extension
  always_comb begin
    ld = dmem_rdata_in;
    case (f3[1:0])
      SZ_B:    ld = f3[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_H:    ld = f3[2] ? {16'b0, half} : {{16{half[15]}}, half};
      default: ld = dmem_rdata_in;
    endcase
  end

  // state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_FETCH;
    else        state <= state_nx;
  end

  // next state and handshake/strobe outputs
  always_comb begin
    state_nx      = state;
    imem_req_out  = 1'b0;
    dmem_req_out  = 1'b0;
    dmem_we_out   = 1'b0;
    dmem_be_out   = 4'h0;
    reg_wr_en_out = 1'b0;
    retire_out    = 1'b0;
    trap_out      = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req_out = ~rst_in;
        if (imem_ack_in) state_nx = S_DECODE;
      end
      S_DECODE: begin
        state_nx = legal_op(op) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (misalign)          state_nx = S_TRAP;
        else if (is_ld || is_st) state_nx = S_MEM;
        else                   state_nx = S_WB;
      end
      S_MEM: begin
        dmem_req_out = 1'b1;
        dmem_we_out  = is_st;
        dmem_be_out  = is_st ? be : 4'h0;
        if (dmem_ack_in) state_nx = S_WB;
      end
      S_WB: begin
        reg_wr_en_out = writes && (rd != 5'd0);
        retire_out    = 1'b1;
        state_nx      = S_FETCH;
      end
      S_TRAP: begin
        trap_out = 1'b1;
      end
      default: state_nx = S_TRAP;
    endcase
  end

  // datapath registers advanced per state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc    <= RESET_PC;
      ir    <= 32'h0;
      a     <= 32'h0;
      b     <= 32'h0;
      imm   <= 32'h0;
      res   <= 32'h0;
      npc   <= 32'h0;
      ea    <= 32'h0;
      be    <= 4'h0;
      wdata <= 32'h0;
    end else begin
      case (state)
        S_FETCH: if (imem_ack_in) ir <= imem_data_in;
        S_DECODE: begin
          a   <= reg_rd_data1_in;
          b   <= reg_rd_data2_in;
          imm <= imm_sel;
        end
        S_EXEC: begin
          res   <= exec_res;
          npc   <= jump ? (tgt & ~32'h2) : pc + 32'd4;
          ea    <= ea_al;
          be    <= st_be;
          wdata <= st_data;
        end
        S_MEM: if (dmem_ack_in && is_ld) res <= ld;
        S_WB: pc <= npc;
        default: ;
      endcase
    end
  end

  assign imem_addr_out   = pc;
  assign pc_out          = pc;
  assign dmem_addr_out   = ea;
  assign dmem_wdata_out  = wdata;
  assign reg_rd_idx1_out = ir[19:15];
  assign reg_rd_idx2_out = ir[24:20];
  assign reg_wr_idx_out  = rd;
  assign reg_wr_data_out = res;
  assign alu_arg1_out    = a;
  assign alu_arg2_out    = is_r ? b :
                           is_shift ? {27'b0, imm[4:0]} : imm;
  assign alu_cid_out     = ALU_CID_W'((is_r || is_shift) ?
                           {f3, f7} : {f3, 7'b0});

endmodule

// File: tb/tb_control_mc.sv
// Directed bench for control_mc: small program with memory wait states,
// behavioural regfile/ALU, checks per retired instruction and trap.
module tb_control_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [31:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [4:0]  idx1, idx2, wr_idx;
  logic [31:0] rd1, rd2, wr_data, arg1, arg2, alu_res, pc;
  logic        wr_en, retire, trap;
  logic [9:0]  cid;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:15];
  logic [31:0] rf   [0:31];
  int iwait, dwait, icnt, dcnt;
  int n_cmp = 0, n_err = 0, n_ret = 0;

  always #5 clk = ~clk;

  control_mc #(.RESET_PC(32'h100), .ALU_CID_W(10)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .imem_req_out    (imem_req),
    .imem_addr_out   (imem_addr),
    .imem_ack_in     (imem_ack),
    .imem_data_in    (imem_data),
    .dmem_req_out    (dmem_req),
    .dmem_we_out     (dmem_we),
    .dmem_addr_out   (dmem_addr),
    .dmem_be_out     (dmem_be),
    .dmem_wdata_out  (dmem_wdata),
    .dmem_ack_in     (dmem_ack),
    .dmem_rdata_in   (dmem_rdata),
    .reg_rd_idx1_out (idx1),
    .reg_rd_idx2_out (idx2),
    .reg_rd_data1_in (rd1),
    .reg_rd_data2_in (rd2),
    .reg_wr_en_out   (wr_en),
    .reg_wr_idx_out  (wr_idx),
    .reg_wr_data_out (wr_data),
    .alu_cid_out     (cid),
    .alu_arg1_out    (arg1),
    .alu_arg2_out    (arg2),
    .alu_res_in      (alu_res),
    .pc_out          (pc),
    .retire_out      (retire),
    .trap_out        (trap)
  );

  assign imem_ack   = imem_req && (icnt == iwait);
  assign imem_data  = imem[imem_addr[9:2]];
  assign dmem_ack   = dmem_req && (dcnt == dwait);
  assign dmem_rdata = dmem[dmem_addr[5:2]];
  assign rd1 = (idx1 == 5'd0) ? 32'h0 : rf[idx1];
  assign rd2 = (idx2 == 5'd0) ? 32'h0 : rf[idx2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    end
  end

  always @(posedge clk) begin
    if (dmem_req && dmem_ack && dmem_we)
      for (int k = 0; k < 4; k++)
        if (dmem_be[k])
          dmem[dmem_addr[5:2]][8*k +: 8] <= dmem_wdata[8*k +: 8];
    if (wr_en && wr_idx != 5'd0) rf[wr_idx] <= wr_data;
    if (retire) n_ret <= n_ret + 1;
  end

  always_comb begin
    alu_res = 32'h0;
    case (cid[9:7])
      3'd0: alu_res = cid[5] ? arg1 - arg2 : arg1 + arg2;
      3'd1: alu_res = arg1 << arg2[4:0];
      3'd2: alu_res = {31'b0, $signed(arg1) < $signed(arg2)};
      3'd3: alu_res = {31'b0, arg1 < arg2};
      3'd4: alu_res = arg1 ^ arg2;
      3'd5: alu_res = cid[5] ? $unsigned($signed(arg1) >>> arg2[4:0])
                             : arg1 >> arg2[4:0];
      3'd6: alu_res = arg1 | arg2;
      default: alu_res = arg1 & arg2;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          iw;
    int          dw;
    int          cyc;
    logic        wen;
    logic [4:0]  idx;
    logic [31:0] wd;
    logic [31:0] npc;
    logic        mem;
    logic [31:0] daddr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] dwd;
  } row_t;

  row_t rows [17];

  logic        c_mem, c_we, c_wen;
  logic [31:0] c_addr, c_dwd, c_wd, c_npc;
  logic [3:0]  c_be;
  logic [4:0]  c_idx;

  task automatic step(output int cyc, output logic tr);
    logic done;
    done = 1'b0;
    cyc = 0;
    tr = 1'b0;
    c_mem = 1'b0;
    c_wen = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (dmem_req && dmem_ack) begin
        c_mem  = 1'b1;
        c_we   = dmem_we;
        c_addr = dmem_addr;
        c_be   = dmem_be;
        c_dwd  = dmem_wdata;
      end
      if (retire) begin
        done  = 1'b1;
        c_wen = wr_en;
        c_idx = wr_idx;
        c_wd  = wr_data;
      end
      if (trap) begin
        done = 1'b1;
        tr   = 1'b1;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    c_npc = imem_addr;
  endtask

  initial begin
    int cyc, n_rows, busy;
    logic tr;
    rst = 1'b1;
    iwait = 0;
    dwait = 0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    dmem[0] = 32'h0000_8000;

    rows[0]  = '{32'h100, 32'hFFF00093, 0, 0, 4, 1'b1, 5'd1, 32'hFFFFFFFF,
                 32'h104, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[1]  = '{32'h104, 32'h00100103, 0, 3, 8, 1'b1, 5'd2, 32'hFFFFFF80,
                 32'h108, 1'b1, 32'h1, 1'b0, 4'h0, 32'h0};
    rows[2]  = '{32'h108, 32'h1234B1B7, 0, 0, 4, 1'b1, 5'd3, 32'h1234B000,
                 32'h10C, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[3]  = '{32'h10C, 32'hBCD18193, 0, 0, 4, 1'b1, 5'd3, 32'h1234ABCD,
                 32'h110, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[4]  = '{32'h110, 32'h00600213, 0, 0, 4, 1'b1, 5'd4, 32'h6,
                 32'h114, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[5]  = '{32'h114, 32'h00321023, 0, 0, 5, 1'b0, 5'd0, 32'h0,
                 32'h118, 1'b1, 32'h6, 1'b1, 4'hC, 32'hABCDABCD};
    rows[6]  = '{32'h118, 32'hF09FF06F, 0, 0, 4, 1'b0, 5'd0, 32'h0,
                 32'h20, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[7]  = '{32'h20, 32'hFE009CE3, 0, 0, 4, 1'b0, 5'd0, 32'h0,
                 32'h18, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[8]  = '{32'h18, 32'h04100293, 0, 0, 4, 1'b1, 5'd5, 32'h41,
                 32'h1C, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[9]  = '{32'h1C, 32'h000280E7, 0, 0, 4, 1'b1, 5'd1, 32'h20,
                 32'h40, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[10] = '{32'h40, 32'h00001397, 2, 0, 6, 1'b1, 5'd7, 32'h1040,
                 32'h44, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[11] = '{32'h44, 32'h40415413, 0, 0, 4, 1'b1, 5'd8, 32'hFFFFFFF8,
                 32'h48, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[12] = '{32'h48, 32'h00601483, 0, 1, 6, 1'b1, 5'd9, 32'hFFFFABCD,
                 32'h4C, 1'b1, 32'h6, 1'b0, 4'h0, 32'h0};
    rows[13] = '{32'h4C, 32'h005001A3, 0, 0, 5, 1'b0, 5'd0, 32'h0,
                 32'h50, 1'b1, 32'h3, 1'b1, 4'h8, 32'h41414141};
    rows[14] = '{32'h50, 32'h00002503, 0, 0, 5, 1'b1, 5'd10, 32'h41008000,
                 32'h54, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[15] = '{32'h54, 32'h00100463, 0, 0, 4, 1'b0, 5'd0, 32'h0,
                 32'h58, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
    rows[16] = '{32'h58, 32'h00202583, 0, 0, 5, 1'b1, 5'd11, 32'h41008000,
                 32'h5C, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0};
    for (int i = 0; i < 17; i++) imem[rows[i].pc[9:2]] = rows[i].inst;
    imem[32'h5C >> 2] = 32'hFFFF_FFFF;
`ifdef CONTROL_MISALIGN_TRAP_EN
    n_rows = 16;
`else
    n_rows = 17;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_addr", imem_addr, 32'h100);
    check("rst_pc", pc, 32'h100);
    check("rst_strobes",
          {28'h0, imem_req, dmem_req, dmem_we, wr_en} |
          {27'h0, retire, trap, dmem_be}, 32'h0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_wdata", dmem_wdata | wr_data, 32'h0);
    check("rst_alu", arg1 | arg2 | {22'h0, cid}, 32'h0);

    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h100);

    for (int i = 0; i < n_rows; i++) begin
      iwait = rows[i].iw;
      dwait = rows[i].dw;
      step(cyc, tr);
      check($sformatf("r%0d_trap", i), {31'h0, tr}, 32'h0);
      check($sformatf("r%0d_cyc", i), 32'(cyc), 32'(rows[i].cyc));
      check($sformatf("r%0d_wen", i), {31'h0, c_wen},
            {31'h0, rows[i].wen});
      if (rows[i].wen) begin
        check($sformatf("r%0d_idx", i), {27'h0, c_idx},
              {27'h0, rows[i].idx});
        check($sformatf("r%0d_wdata", i), c_wd, rows[i].wd);
      end
      check($sformatf("r%0d_npc", i), c_npc, rows[i].npc);
      check($sformatf("r%0d_mem", i), {31'h0, c_mem},
            {31'h0, rows[i].mem});
      if (rows[i].mem && c_mem) begin
        check($sformatf("r%0d_daddr", i), c_addr, rows[i].daddr);
        check($sformatf("r%0d_we", i), {31'h0, c_we},
              {31'h0, rows[i].we});
        if (rows[i].we) begin
          check($sformatf("r%0d_be", i), {28'h0, c_be},
                {28'h0, rows[i].be});
          check($sformatf("r%0d_st", i), c_dwd, rows[i].dwd);
        end
      end
    end

    check("mem_w0", dmem[0], 32'h41008000);
    check("mem_w1", dmem[1], 32'hABCD0000);

    iwait = 0;
    dwait = 0;
    step(cyc, tr);
    check("trap_hit", {31'h0, tr}, 32'h1);
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req || dmem_req || wr_en || retire) busy++;
    end
    check("trap_quiet", 32'(busy), 32'h0);
    check("trap_sticky", {31'h0, trap}, 32'h1);
    check("retire_count", 32'(n_ret), 32'(n_rows));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
